// File: rtl/spi_flash_writer_pkg.sv
// Shared constants for the SPI flash writer: flash opcodes, geometry,
// controller state encoding and command-byte helper.
package spi_flash_writer_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_RDSR = 8'h05;

  localparam int PAGE_SIZE   = 256;
  localparam int SECTOR_SIZE = 4096;

  // Controller states (legacy-compatible constant encoding)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WREN    = 3'd1;
  localparam logic [2:0] ST_ERASE   = 3'd2;
  localparam logic [2:0] ST_PROGRAM = 3'd3;
  localparam logic [2:0] ST_POLL    = 3'd4;
  localparam logic [2:0] ST_NEXT    = 3'd5;
  localparam logic [2:0] ST_FINISH  = 3'd6;
  localparam logic [2:0] ST_FAIL    = 3'd7;

  // Per-byte phases inside a command state
  localparam logic [2:0] SUB_GAP  = 3'd0;
  localparam logic [2:0] SUB_PREP = 3'd1;
  localparam logic [2:0] SUB_RAM1 = 3'd2;
  localparam logic [2:0] SUB_RAM2 = 3'd3;
  localparam logic [2:0] SUB_LOAD = 3'd4;
  localparam logic [2:0] SUB_WAIT = 3'd5;

  // Opcode/address header byte idx (0..3) of the command issued in state st
  function automatic logic [7:0] cmd_byte(input logic [2:0] st, input logic [1:0] idx,
                                          input logic [23:0] fa);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      2'd0: begin
        case (st)
          ST_WREN:    b = OP_WREN;
          ST_ERASE:   b = OP_SE;
          ST_PROGRAM: b = OP_PP;
          default:    b = OP_RDSR;
        endcase
      end
      2'd1:    b = fa[23:16];
      2'd2:    b = (st == ST_ERASE) ? {fa[15:12], 4'h0} : fa[15:8];
      default: b = (st == ST_ERASE) ? 8'h00 : fa[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_flash_writer_shifter.sv
// spi_byte_shifter: one SPI mode-0 byte, MSB first, SCK half-period of
// CLK_DIV clocks. MOSI moves only on falling edges; MISO sampled on rising.
module spi_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_tx,
  input  logic       i_miso,
  output logic       o_sck,
  output logic       o_mosi,
  output logic [7:0] o_rx,
  output logic       o_done
);

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic        r_sck;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_sh;
  logic [7:0]  r_rx;

  // Divider, edge generation and shift/sample of one byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= 16'd0;
      r_bit  <= 3'd0;
      r_sck  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sh   <= 8'h00;
      r_rx   <= 8'h00;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_load) begin
          r_sh   <= i_tx;
          r_busy <= 1'b1;
          r_cnt  <= 16'd0;
          r_bit  <= 3'd0;
          r_sck  <= 1'b0;
        end
      end else if (r_cnt == DIV_M1) begin
        r_cnt <= 16'd0;
        if (!r_sck) begin
          r_sck <= 1'b1;
          r_rx  <= {r_rx[6:0], i_miso};
        end else begin
          r_sck <= 1'b0;
          if (r_bit == 3'd7) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_bit <= r_bit + 3'd1;
            r_sh  <= {r_sh[6:0], 1'b0};
          end
        end
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign o_sck  = r_sck;
  assign o_mosi = r_sh[7];
  assign o_rx   = r_rx;
  assign o_done = r_done;

endmodule

// File: rtl/spi_flash_writer.sv
// Copies a RAM region into SPI NOR flash: sector erase on entry to each
// sector, page-bounded programs, status polling with a timeout.
module spi_flash_writer
  import spi_flash_writer_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int POLL_LIMIT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] flash_address,
  input  logic [16:0] length,
  input  logic [15:0] ram_start,
  output logic [15:0] ram_address,
  input  logic [7:0]  ram_dataout,
  output logic        ram_cs,
  output logic        spi_clk,
  output logic        spi_out,
  input  logic        spi_miso,
  output logic        spi_cs,
  output logic        busy,
  output logic        done,
  output logic        error
);

  // Chip select stays high for two full SCK periods before every command
  localparam logic [15:0] GAP_M1 = 16'(4 * CLK_DIV - 1);
  localparam logic [16:0] POLL_M = 17'(POLL_LIMIT);

  logic [2:0]  r_state, r_sub, r_tgt;
  logic        r_after_prog, r_first, r_cs, r_ram_cs, r_error;
  logic [23:0] r_fa;
  logic [15:0] r_ra, r_ram_addr, r_gap;
  logic [16:0] r_rem, r_polls;
  logic [8:0]  r_burst, r_idx;
  logic [7:0]  r_tx;

  logic        w_sh_load, w_sh_done, w_data_byte;
  logic [7:0]  w_rx;
  logic [23:0] w_fa_nx;
  logic [15:0] w_ra_nx;
  logic [16:0] w_rem_nx;
  logic [8:0]  w_room, w_burst_nx, w_last_idx;

  assign w_fa_nx    = r_fa + 24'(r_burst);
  assign w_ra_nx    = r_ra + 16'(r_burst);
  assign w_rem_nx   = r_rem - 17'(r_burst);
  assign w_room     = 9'(PAGE_SIZE) - {1'b0, w_fa_nx[7:0]};
  assign w_burst_nx = (w_rem_nx < {8'd0, w_room}) ? w_rem_nx[8:0] : w_room;
  assign w_data_byte = (r_state == ST_PROGRAM) && (r_idx >= 9'd4);
  assign w_sh_load  = (r_sub == SUB_LOAD) &&
                      (r_state == ST_WREN || r_state == ST_ERASE ||
                       r_state == ST_PROGRAM || r_state == ST_POLL);

  // Index of the final byte of the current (non-poll) command
  always_comb begin
    w_last_idx = 9'd0;
    case (r_state)
      ST_ERASE:   w_last_idx = 9'd3;
      ST_PROGRAM: w_last_idx = 9'd3 + r_burst;
      default:    w_last_idx = 9'd0;
    endcase
  end

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_sh_load),
    .i_tx   (r_tx),
    .i_miso (spi_miso),
    .o_sck  (spi_clk),
    .o_mosi (spi_out),
    .o_rx   (w_rx),
    .o_done (w_sh_done)
  );

  // Job sequencing, per-command byte stepping and RAM fetches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;   r_sub <= SUB_GAP;    r_tgt <= ST_ERASE;
      r_after_prog <= 1'b0; r_first <= 1'b0;     r_cs <= 1'b1;
      r_ram_cs <= 1'b0;     r_error <= 1'b0;     r_fa <= 24'd0;
      r_ra <= 16'd0;        r_ram_addr <= 16'd0; r_gap <= 16'd0;
      r_rem <= 17'd0;       r_polls <= 17'd0;    r_burst <= 9'd0;
      r_idx <= 9'd0;        r_tx <= 8'h00;
    end else begin
      r_ram_cs <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_error <= 1'b0;
            r_fa    <= flash_address;
            r_ra    <= ram_start;
            r_rem   <= length;
            r_burst <= 9'd0;
            r_first <= 1'b1;
            r_state <= (length == 17'd0) ? ST_FINISH : ST_NEXT;
          end
        end
        ST_NEXT: begin
          r_fa  <= w_fa_nx;
          r_ra  <= w_ra_nx;
          r_rem <= w_rem_nx;
          if (w_rem_nx == 17'd0) begin
            r_state <= ST_FINISH;
          end else begin
            r_burst <= w_burst_nx;
            r_tgt   <= (r_first || (w_fa_nx & 24'(SECTOR_SIZE - 1)) == 24'd0)
                       ? ST_ERASE : ST_PROGRAM;
            r_first <= 1'b0;
            r_state <= ST_WREN;
            r_sub   <= SUB_GAP;
            r_gap   <= 16'd0;
          end
        end
        ST_FINISH, ST_FAIL: r_state <= ST_IDLE;
        default: begin
          case (r_sub)
            SUB_GAP: begin
              if (r_gap == GAP_M1) begin
                r_cs    <= 1'b0;
                r_idx   <= 9'd0;
                r_polls <= 17'd0;
                r_sub   <= SUB_PREP;
              end else begin
                r_gap <= r_gap + 16'd1;
              end
            end
            SUB_PREP: begin
              if (w_data_byte) begin
                r_ram_cs   <= 1'b1;
                r_ram_addr <= r_ra + 16'(r_idx - 9'd4);
                r_sub      <= SUB_RAM1;
              end else begin
                r_tx  <= (r_state == ST_POLL && r_idx != 9'd0) ? 8'h00
                         : cmd_byte(r_state, r_idx[1:0], r_fa);
                r_sub <= SUB_LOAD;
              end
            end
            SUB_RAM1: r_sub <= SUB_RAM2;
            SUB_RAM2: begin
              r_tx  <= ram_dataout;
              r_sub <= SUB_LOAD;
            end
            SUB_LOAD: r_sub <= SUB_WAIT;
            default: begin
              if (w_sh_done) begin
                r_idx <= (r_state == ST_POLL) ? 9'd1 : r_idx + 9'd1;
                if (r_state == ST_POLL && r_idx != 9'd0) begin
                  if ((w_rx & 8'h01) == 8'h00) begin
                    r_cs    <= 1'b1;
                    r_state <= r_after_prog ? ST_NEXT : ST_WREN;
                    r_tgt   <= ST_PROGRAM;
                    r_sub   <= SUB_GAP;
                    r_gap   <= 16'd0;
                  end else if (r_polls == POLL_M) begin
                    r_cs    <= 1'b1;
                    r_error <= 1'b1;
                    r_state <= ST_FAIL;
                  end else begin
                    r_polls <= r_polls + 17'd1;
                    r_sub   <= SUB_PREP;
                  end
                end else if (r_state != ST_POLL && r_idx == w_last_idx) begin
                  r_cs  <= 1'b1;
                  r_sub <= SUB_GAP;
                  r_gap <= 16'd0;
                  case (r_state)
                    ST_WREN:  r_state <= r_tgt;
                    ST_ERASE: begin
                      r_state      <= ST_POLL;
                      r_after_prog <= 1'b0;
                    end
                    default: begin
                      r_state      <= ST_POLL;
                      r_after_prog <= 1'b1;
                    end
                  endcase
                end else begin
                  r_sub <= SUB_PREP;
                end
              end
            end
          endcase
        end
      endcase
    end
  end

  assign spi_cs      = r_cs;
  assign ram_cs      = r_ram_cs;
  assign ram_address = r_ram_addr;
  assign error       = r_error;
  assign done        = (r_state == ST_FINISH);
  assign busy        = (r_state != ST_IDLE) && (r_state != ST_FINISH) && (r_state != ST_FAIL);

endmodule

// File: tb/tb_spi_flash_writer.sv
// Bench for spi_flash_writer: behavioural SPI flash and RAM, expected
// command stream computed from job parameters, protocol monitors.
module tb_spi_flash_writer;

  localparam int CLK_DIV    = 3;
  localparam int POLL_LIMIT = 8;
  localparam int BUDGET     = 20000;

  logic        clk, reset, start;
  logic [23:0] flash_address;
  logic [16:0] length;
  logic [15:0] ram_start, ram_address;
  logic [7:0]  ram_dataout, ram_q;
  logic        ram_cs, spi_clk, spi_out, spi_miso, spi_cs, busy, done, error;

  spi_flash_writer #(.CLK_DIV(CLK_DIV), .POLL_LIMIT(POLL_LIMIT)) dut (
    .clk(clk), .reset(reset), .start(start), .flash_address(flash_address),
    .length(length), .ram_start(ram_start), .ram_address(ram_address),
    .ram_dataout(ram_dataout), .ram_cs(ram_cs), .spi_clk(spi_clk),
    .spi_out(spi_out), .spi_miso(spi_miso), .spi_cs(spi_cs), .busy(busy),
    .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [7:0] op; logic [23:0] addr; int nbytes;} txn_t;

  int n_checks, n_err;
  logic [7:0] mem [65536];
  txn_t log_q[$], exp_q[$];
  logic [7:0] data_q[$], exp_data[$], cur_bytes[$];
  logic [7:0] shreg;
  int bitcnt, status_reads, wip_cnt, cs_falls, hi_cnt;
  int sck_viol, mosi_viol, gap_viol, ramcs_viol, wel_viol;
  bit wip_forever, wel, cur_wip;
  logic prev_mosi;

  // Synchronous source RAM: data one clock after the strobe
  always @(posedge clk) if (ram_cs) ram_q <= mem[ram_address];
  assign ram_dataout = ram_q;

  // Flash: start of transaction, chip-select gap measurement
  always @(negedge spi_cs) begin
    if (hi_cnt < 4 * CLK_DIV) gap_viol++;
    bitcnt = 0;
    cur_bytes.delete();
    spi_miso = 1'b0;
    cs_falls++;
  end

  // Flash: assemble MOSI bytes on SCK rising edges
  always @(posedge spi_clk) begin
    if (!spi_cs) begin
      shreg = {shreg[6:0], spi_out};
      bitcnt++;
      if (bitcnt % 8 == 0) begin
        cur_bytes.push_back(shreg);
        if (cur_bytes[0] == 8'h05 && cur_bytes.size() > 1) status_reads++;
      end
    end
  end

  // Flash: status byte output on SCK falling edges, WIP in bit 0
  always @(negedge spi_clk) begin
    if (!spi_cs && cur_bytes.size() >= 1 && cur_bytes[0] == 8'h05) begin
      if (bitcnt % 8 == 0) begin
        if (wip_forever) cur_wip = 1'b1;
        else if (wip_cnt > 0) begin cur_wip = 1'b1; wip_cnt--; end
        else cur_wip = 1'b0;
      end
      spi_miso = (bitcnt % 8 == 7) ? cur_wip : 1'b0;
    end
  end

  // Flash: end of transaction, log it and update WEL/WIP
  always @(posedge spi_cs) begin
    txn_t t;
    if (cur_bytes.size() > 0) begin
      t.op = cur_bytes[0];
      t.addr = (cur_bytes.size() >= 4) ? {cur_bytes[1], cur_bytes[2], cur_bytes[3]} : 24'd0;
      t.nbytes = cur_bytes.size();
      log_q.push_back(t);
      if (t.op == 8'h02) for (int i = 4; i < cur_bytes.size(); i++) data_q.push_back(cur_bytes[i]);
      if (t.op == 8'h06) wel = 1'b1;
      if (t.op == 8'h20 || t.op == 8'h02) begin
        if (!wel) wel_viol++;
        wel = 1'b0;
        wip_cnt = $urandom_range(0, 3);
      end
    end
  end

  // Pin-level protocol monitors sampled mid-cycle
  always @(negedge clk) begin
    if (spi_cs) hi_cnt++; else hi_cnt = 0;
    if (spi_cs && spi_clk) sck_viol++;
    if (spi_clk && spi_out !== prev_mosi) mosi_viol++;
    prev_mosi = spi_out;
    if (ram_cs && !(!spi_cs && cur_bytes.size() >= 4 && cur_bytes[0] == 8'h02)) ramcs_viol++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] op, input logic [23:0] addr, input int nb);
    txn_t t;
    t.op = op; t.addr = addr; t.nbytes = nb;
    exp_q.push_back(t);
  endtask

  // Expected command stream derived from the job parameters alone
  task automatic build_expect(input logic [23:0] fa, input int len, input logic [15:0] ra);
    int pos, a, burst;
    bit first;
    exp_q.delete(); exp_data.delete();
    pos = 0; first = 1;
    while (pos < len) begin
      a = (int'(fa) + pos) % (1 << 24);
      if (first || a % 4096 == 0) begin
        push_exp(8'h06, 24'd0, 1);
        push_exp(8'h20, 24'(a - a % 4096), 4);
        push_exp(8'h05, 24'd0, 0);
      end
      burst = len - pos;
      if (256 - a % 256 < burst) burst = 256 - a % 256;
      push_exp(8'h06, 24'd0, 1);
      push_exp(8'h02, 24'(a), 4 + burst);
      push_exp(8'h05, 24'd0, 0);
      for (int i = 0; i < burst; i++) exp_data.push_back(mem[(int'(ra) + pos + i) % 65536]);
      pos += burst;
      first = 0;
    end
  endtask

  task automatic compare_logs(input string tag);
    check({tag, " txn_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check($sformatf("%s op[%0d]", tag, i), 64'(log_q[i].op), 64'(exp_q[i].op));
      if (exp_q[i].op == 8'h20 || exp_q[i].op == 8'h02)
        check($sformatf("%s addr[%0d]", tag, i), 64'(log_q[i].addr), 64'(exp_q[i].addr));
      if (exp_q[i].op != 8'h05)
        check($sformatf("%s nbytes[%0d]", tag, i), 64'(log_q[i].nbytes), 64'(exp_q[i].nbytes));
      else
        check($sformatf("%s poll_len[%0d]", tag, i), 64'(log_q[i].nbytes >= 2), 64'd1);
    end
    check({tag, " data_count"}, 64'(data_q.size()), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < data_q.size(); i++)
      check($sformatf("%s data[%0d]", tag, i), 64'(data_q[i]), 64'(exp_data[i]));
    check({tag, " protocol"}, 64'(sck_viol + mosi_viol + gap_viol + ramcs_viol + wel_viol), 64'd0);
  endtask

  task automatic run_job(input logic [23:0] fa, input logic [16:0] len, input logic [15:0] ra,
                         input string tag, input bit exp_fail);
    int cyc;
    bit saw_done, saw_err;
    log_q.delete(); data_q.delete(); status_reads = 0;
    build_expect(fa, int'(len), ra);
    if (exp_fail) begin
      while (exp_q.size() > 3) void'(exp_q.pop_back());
      exp_data.delete();
    end
    @(negedge clk);
    flash_address = fa; length = len; ram_start = ra; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    check({tag, " error_cleared"}, 64'(error), 64'd0);
    cyc = 0;
    while (cyc < BUDGET && !done && !error) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " in_budget"}, 64'(cyc < BUDGET), 64'd1);
    saw_done = done; saw_err = error;
    check({tag, " done"}, 64'(saw_done), 64'(!exp_fail));
    check({tag, " error"}, 64'(saw_err), 64'(exp_fail));
    check({tag, " busy_low_at_end"}, 64'(busy), 64'd0);
    check({tag, " cs_high_at_end"}, 64'(spi_cs), 64'd1);
    @(negedge clk);
    check({tag, " done_one_cycle"}, 64'(done), 64'd0);
    repeat (8 * CLK_DIV) @(negedge clk);
    compare_logs(tag);
  endtask

  initial begin
    logic [23:0] rfa;
    int snap, cyc;
    n_checks = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; flash_address = 24'd0; length = 17'd0; ram_start = 16'd0;
    spi_miso = 1'b0; wip_forever = 1'b0; wel = 1'b0; wip_cnt = 0; cs_falls = 0; hi_cnt = 0;
    sck_viol = 0; mosi_viol = 0; gap_viol = 0; ramcs_viol = 0; wel_viol = 0; prev_mosi = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    check("rst spi_cs", 64'(spi_cs), 64'd1);
    check("rst spi_clk", 64'(spi_clk), 64'd0);
    check("rst spi_out", 64'(spi_out), 64'd0);
    check("rst ram_cs", 64'(ram_cs), 64'd0);
    check("rst ram_address", 64'(ram_address), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst error", 64'(error), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_job(24'h010000, 17'd16, 16'hF000, "basic", 1'b0);
    run_job(24'h0100F0, 17'd32, 16'h1234, "page_split", 1'b0);
    run_job(24'h000FFE, 17'd4,  16'h0040, "sector_split", 1'b0);
    run_job(24'hFFFFF8, 17'd16, 16'hFFFC, "wrap", 1'b0);
    for (int k = 0; k < 4; k++) begin
      rfa = 24'($urandom);
      if (k % 2 == 0) rfa[11:0] = 12'hFFF - 12'($urandom_range(0, 30));
      run_job(rfa, 17'($urandom_range(1, 40)), 16'($urandom), $sformatf("rand%0d", k), 1'b0);
    end

    wip_forever = 1'b1;
    run_job(24'h030000, 17'd8, 16'h0000, "timeout", 1'b1);
    wip_forever = 1'b0;
    check("timeout status_reads", 64'(status_reads), 64'(POLL_LIMIT + 1));
    if (log_q.size() >= 3) check("timeout poll_nbytes", 64'(log_q[2].nbytes), 64'(POLL_LIMIT + 2));
    repeat (5) @(negedge clk);
    check("timeout error_sticky", 64'(error), 64'd1);
    run_job(24'h040010, 17'd5, 16'h0100, "after_fail", 1'b0);

    // Reset in the middle of a program data byte
    log_q.delete(); data_q.delete();
    @(negedge clk);
    flash_address = 24'h020000; length = 17'd20; ram_start = 16'h0200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < BUDGET && !(!spi_cs && cur_bytes.size() >= 5 && cur_bytes[0] == 8'h02 && spi_clk)) begin
      @(negedge clk);
      cyc++;
    end
    check("midreset reached_data", 64'(cyc < BUDGET), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("midreset spi_cs", 64'(spi_cs), 64'd1);
    check("midreset spi_clk", 64'(spi_clk), 64'd0);
    check("midreset ram_cs", 64'(ram_cs), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    snap = cs_falls;
    repeat (300) @(negedge clk);
    check("midreset no_resume", 64'(cs_falls - snap), 64'd0);
    check("midreset idle", 64'(busy), 64'd0);

    // Zero-length job
    snap = cs_falls;
    flash_address = 24'h123456; length = 17'd0; ram_start = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0 done", 64'(done), 64'd1);
    check("len0 busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("len0 done_pulse", 64'(done), 64'd0);
    repeat (50) @(negedge clk);
    check("len0 no_spi", 64'(cs_falls - snap), 64'd0);
    check("final protocol", 64'(sck_viol + mosi_viol + gap_viol + ramcs_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
